riscv_mem_responder: RTL and testbench
======================================

Name: riscv_mem_responder

Overview:
Memory-side responder for the L2 cache's memory interface. It is the target end of the mem_addr/mem_read/mem_write/mem_wdata to mem_rdata/mem_ready protocol that the L2 drives on a miss. It backs a word-addressed on-chip array and answers each request after a fixed, parameterised latency with a single-cycle mem_ready pulse. It serves as the simulation/FPGA main-memory model behind riscv_l2_cache.

Parameters:
MEM_WORDS, 16384, number of 32-bit words in the backing array; must be a power of 2
LATENCY, 4, cycles from request acceptance to mem_ready; legal range 1..255
INIT_VALUE, 32'h0000_0000, value returned for a word never written (simulation init only)

Ports:
clk  input  1  single clock, all logic rising-edge
rst_n  input  1  reset, synchronous, active-low
mem_addr  input  32  byte address; word index = mem_addr[$clog2(MEM_WORDS)+1:2]; bits [1:0] ignored
mem_read  input  1  read request, level; held by initiator until mem_ready
mem_write  input  1  write request, level; held by initiator until mem_ready
mem_wdata  input  32  write data, valid with mem_write
mem_rdata  output  32  read data, valid only in the mem_ready cycle
mem_ready  output  1  one-cycle completion pulse

Behaviour:
- Reset (rst_n low at a clock edge): state=IDLE, latency counter=0, mem_ready=0, mem_rdata=0. Array contents are NOT reset and are retained across reset. A reset asserted mid-transaction aborts it: no write is committed and no mem_ready is issued.
- States: IDLE, BUSY, RESP.
- IDLE: if (mem_read|mem_write) is high in cycle T, latch addr, wdata, rd and wr, load the counter with LATENCY-1, and go to BUSY. If LATENCY==1, go directly to RESP. Otherwise stay in IDLE.
- BUSY: decrement the counter each cycle. When the counter reaches 0, go to RESP. Input changes during BUSY are ignored because the request is already latched.
- RESP: mem_ready=1 for exactly this cycle, which is cycle T+LATENCY.
  - If wr is latched, commit array[idx] <= wdata on this edge.
  - If rd is latched, mem_rdata = array[idx] sampled in BUSY/RESP.
  - Next state is always IDLE.
- Read and write latched together: a single transaction. The write is committed and mem_rdata returns the written data (write-first).
- The mandatory IDLE cycle after RESP gives a turnaround. A request still held in that IDLE cycle starts a new transaction; the L2 re-issues on repeated misses, so this is correct. Throughput is therefore 1 transaction per LATENCY+1 cycles.
- Address wrap: the upper address bits above the index are ignored, so addresses alias modulo MEM_WORDS*4.
- mem_rdata holds its last value when mem_ready=0. For a write-only transaction it is don't-care, and the implementation drives the written data.
- The array is a synchronous 1R1W. The read is issued in the last BUSY cycle, or in the IDLE accept cycle when LATENCY==1, so data is ready in RESP.

Optional Feature:
Macro RISCV_MEM_RESP_BOUNDS_CHECK_EN, with localparam MEM_BASE=32'h8000_0000.
- Defined: a request with mem_addr outside [MEM_BASE, MEM_BASE+MEM_WORDS*4) still completes with normal latency. A read returns 32'hDEAD_BEEF and a write is dropped. A simulation-only $error is printed per out-of-range access.
- Undefined: no range check; addresses alias as described above.

Decomposition:
- Package riscv_mem_pkg:
  - mem_resp_state_e (IDLE/BUSY/RESP, 2-bit)
  - DEADBEEF_C constant
  - MEM_BASE_C constant
  - mem_req_t struct {addr, wdata, rd, wr}
- One sub-module, riscv_mem_array: parameterised 1R1W synchronous SRAM model (we, waddr, wdata, re, raddr, rdata), no reset.
- FSM, counter and request latch stay in riscv_mem_responder.

Test Plan:
- Reset then write: mem_write=1, addr=0x0000_0040, wdata=0xA5A5_1234, held. mem_ready pulses exactly at T+4 (LATENCY=4) for one cycle, then IDLE.
- Readback: mem_read=1, addr=0x0000_0040. mem_ready at T+4 with mem_rdata=0xA5A5_1234. Holding mem_read gives a second pulse at T+9.
- Simultaneous: mem_read=mem_write=1, addr=0x100, wdata=0x0BAD_F00D. One pulse with mem_rdata=0x0BAD_F00D; a later read of 0x100 returns 0x0BAD_F00D.
- Reset mid-op: write to 0x200 accepted; rst_n low at T+2 for one cycle. No mem_ready is seen; a later read of 0x200 returns the prior value (INIT_VALUE).
- Wrap and latency 1: with LATENCY=1 and MEM_WORDS=16384, write 0x1 to 0x0001_0004, then read 0x0000_0004. Each ready arrives at T+1 and the read returns 0x1. With RISCV_MEM_RESP_BOUNDS_CHECK_EN defined, reading 0x0000_0004 returns 0xDEAD_BEEF.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared types and constants for the memory responder
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_resp_state_e;

    localparam logic [31:0] DEADBEEF_C = 32'hDEAD_BEEF;
    localparam logic [31:0] MEM_BASE_C = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rd;
        logic        wr;
    } mem_req_t;

    // True when a byte address falls inside [MEM_BASE_C, MEM_BASE_C + words*4).
    // 33-bit arithmetic so the upper limit cannot wrap.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned words);
        logic [32:0] lo;
        logic [32:0] hi;
        logic [32:0] a;
        lo = {1'b0, MEM_BASE_C};
        hi = lo + ({1'b0, 32'(words)} << 2);
        a  = {1'b0, addr};
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/riscv_mem_array.sv
// rtl/riscv_mem_array.sv - 1R1W synchronous word array, no reset
module riscv_mem_array #(
    parameter int unsigned WORDS      = 16384,
    parameter int unsigned AW         = $clog2(WORDS),
    parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    // Contents start at INIT_VALUE in simulation/FPGA bitstreams; never reset.
    logic [31:0] mem [WORDS] = '{default: INIT_VALUE};

    // Write port: commit on the clock edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: registered output, holds when not enabled (read-first on collision).
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/riscv_mem_responder.sv
// rtl/riscv_mem_responder.sv - fixed-latency memory target behind the L2 (optional RISCV_MEM_RESP_BOUNDS_CHECK_EN)
module riscv_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS  = 16384,
    parameter int unsigned LATENCY    = 4,
    parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_addr,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready
);

    localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
    localparam logic [7:0]  LAT_M1 = 8'(LATENCY - 1);

    mem_resp_state_e state;
    mem_resp_state_e state_next;
    logic [7:0]      cnt;
    mem_req_t        req;
    logic [31:0]     rdata_q;

    logic             accept;
    logic             req_ok;
    logic             arr_we;
    logic             arr_re;
    logic [IDX_W-1:0] arr_raddr;
    logic [31:0]      arr_rdata;
    logic [31:0]      resp_data;
    logic             unused_bits;

    assign accept = (state == IDLE) && (mem_read || mem_write);

`ifdef RISCV_MEM_RESP_BOUNDS_CHECK_EN
    assign req_ok = addr_in_range(req.addr, MEM_WORDS);

    // Report every out-of-range request as it is accepted.
    always_ff @(posedge clk) begin
        if (rst_n && accept && !addr_in_range(mem_addr, MEM_WORDS)) begin
            $error("riscv_mem_responder: out-of-range access addr=%h", mem_addr);
        end
    end
`else
    assign req_ok = 1'b1;
`endif

    // Only part of the latched address forms the word index; the rest aliases.
    assign unused_bits = ^{req.addr[31:IDX_W+2], req.addr[1:0]};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: accept in IDLE, count down in BUSY, RESP always lasts one cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (mem_read || mem_write) begin
                    state_next = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (cnt == 8'd1) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latency counter: loaded on accept, decremented while BUSY.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (accept) begin
            cnt <= LAT_M1;
        end else if (state == BUSY) begin
            cnt <= cnt - 8'd1;
        end
    end

    // Request latch: inputs are ignored once a transaction is in flight.
    always_ff @(posedge clk) begin
        if (accept) begin
            req.addr  <= mem_addr;
            req.wdata <= mem_wdata;
            req.rd    <= mem_read;
            req.wr    <= mem_write;
        end
    end

    // Array read happens one cycle before RESP so the data lands in RESP.
    always_comb begin
        if (LATENCY == 1) begin
            arr_re    = accept && mem_read;
            arr_raddr = mem_addr[IDX_W+1:2];
        end else begin
            arr_re    = (state == BUSY) && (cnt == 8'd1) && req.rd;
            arr_raddr = req.addr[IDX_W+1:2];
        end
    end

    // Writes commit on the RESP edge; a reset in that cycle still aborts them.
    assign arr_we = (state == RESP) && req.wr && req_ok && rst_n;

    riscv_mem_array #(
        .WORDS      (MEM_WORDS),
        .AW         (IDX_W),
        .INIT_VALUE (INIT_VALUE)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (req.addr[IDX_W+1:2]),
        .wdata (req.wdata),
        .re    (arr_re),
        .raddr (arr_raddr),
        .rdata (arr_rdata)
    );

    // Response data: write-first when a write is latched, poison when out of range.
    always_comb begin
        resp_data = arr_rdata;
        if (!req_ok) begin
            resp_data = DEADBEEF_C;
        end else if (req.wr) begin
            resp_data = req.wdata;
        end
    end

    // Hold register so mem_rdata keeps the last response outside RESP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= 32'h0000_0000;
        end else if (state == RESP) begin
            rdata_q <= resp_data;
        end
    end

    // Outputs: ready is exactly the RESP cycle.
    always_comb begin
        mem_ready = (state == RESP);
        mem_rdata = (state == RESP) ? resp_data : rdata_q;
    end

endmodule

// File: tb/tb_riscv_mem_responder.sv
// tb/tb_riscv_mem_responder.sv - directed self-checking bench for riscv_mem_responder
module tb_riscv_mem_responder;

`ifdef RISCV_MEM_RESP_BOUNDS_CHECK_EN
    localparam logic [31:0] AB      = 32'h8000_0000;
    localparam logic [31:0] WRAP_RD = 32'hDEAD_BEEF;
`else
    localparam logic [31:0] AB      = 32'h0000_0000;
    localparam logic [31:0] WRAP_RD = 32'h0000_0001;
`endif
    localparam logic [31:0] INIT_V = 32'h1357_9BDF;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    logic [31:0] d1_addr;
    logic        d1_read;
    logic        d1_write;
    logic [31:0] d1_wdata;
    logic [31:0] d1_rdata;
    logic        d1_ready;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd_val;

    riscv_mem_responder #(
        .MEM_WORDS  (16384),
        .LATENCY    (4),
        .INIT_VALUE (INIT_V)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_addr  (mem_addr),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    riscv_mem_responder #(
        .MEM_WORDS  (16384),
        .LATENCY    (1),
        .INIT_VALUE (32'h0000_0000)
    ) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_addr  (d1_addr),
        .mem_read  (d1_read),
        .mem_write (d1_write),
        .mem_wdata (d1_wdata),
        .mem_rdata (d1_rdata),
        .mem_ready (d1_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
        if (sel) begin
            d1_read = rd; d1_write = wr; d1_addr = a; d1_wdata = wd;
        end else begin
            mem_read = rd; mem_write = wr; mem_addr = a; mem_wdata = wd;
        end
    endtask

    // One transaction: request held until the ready cycle, then dropped.
    task automatic txn(input bit sel, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input int lat, input string tag, output logic [31:0] data);
        logic rdy;
        data = 32'h0;
        drive(sel, rd, wr, a, wd);
        for (int k = 1; k <= lat + 2; k++) begin
            tick();
            rdy = sel ? d1_ready : mem_ready;
            check($sformatf("%s_rdy_T+%0d", tag, k), {31'b0, rdy}, {31'b0, (k == lat)});
            if (k == lat) begin
                data = sel ? d1_rdata : mem_rdata;
                drive(sel, 1'b0, 1'b0, a, wd);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) tick();
        check("reset_ready", {31'b0, mem_ready}, 32'h0);
        check("reset_rdata", mem_rdata, 32'h0);
        check("reset_ready_l1", {31'b0, d1_ready}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Write then read back at latency 4.
        txn(1'b0, 1'b0, 1'b1, AB + 32'h40, 32'hA5A5_1234, 4, "wr40", rd_val);
        check("wr40_rdata", rd_val, 32'hA5A5_1234);
        tick();

        // Held read: pulses at T+4 and T+9, data held afterwards.
        drive(1'b0, 1'b1, 1'b0, AB + 32'h40, 32'h0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("hold_rdy_T+%0d", k), {31'b0, mem_ready}, {31'b0, (k == 4 || k == 9)});
            if (k == 4 || k == 9) check($sformatf("hold_rdata_T+%0d", k), mem_rdata, 32'hA5A5_1234);
            if (k == 9) drive(1'b0, 1'b0, 1'b0, AB + 32'h40, 32'h0);
        end
        check("hold_rdata_kept", mem_rdata, 32'hA5A5_1234);

        // Simultaneous read+write is one write-first transaction.
        txn(1'b0, 1'b1, 1'b1, AB + 32'h100, 32'h0BAD_F00D, 4, "rw100", rd_val);
        check("rw100_rdata", rd_val, 32'h0BAD_F00D);
        tick();
        txn(1'b0, 1'b1, 1'b0, AB + 32'h100, 32'h0, 4, "rd100", rd_val);
        check("rd100_rdata", rd_val, 32'h0BAD_F00D);
        tick();

        // Reset during BUSY aborts the write and suppresses mem_ready.
        drive(1'b0, 1'b0, 1'b1, AB + 32'h200, 32'hFFFF_0000);
        tick();
        check("rst_mid_rdy_T+1", {31'b0, mem_ready}, 32'h0);
        tick();
        check("rst_mid_rdy_T+2", {31'b0, mem_ready}, 32'h0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, AB + 32'h200, 32'h0);
        check("rst_mid_rdata_cleared", mem_rdata, 32'h0);
        for (int k = 3; k <= 6; k++) begin
            check($sformatf("rst_mid_rdy_T+%0d", k), {31'b0, mem_ready}, 32'h0);
            tick();
        end
        txn(1'b0, 1'b1, 1'b0, AB + 32'h200, 32'h0, 4, "rd200", rd_val);
        check("rd200_init", rd_val, INIT_V);
        tick();

        // Latency 1 with address aliasing modulo MEM_WORDS*4.
        txn(1'b1, 1'b0, 1'b1, 32'h0001_0004, 32'h0000_0001, 1, "l1_wr", rd_val);
        tick();
        txn(1'b1, 1'b1, 1'b0, 32'h0000_0004, 32'h0, 1, "l1_rd", rd_val);
        check("l1_wrap_rdata", rd_val, WRAP_RD);
        check("l1_rdata_kept", d1_rdata, WRAP_RD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
